// File: rtl/mem_io_bridge_pkg.sv
// Shared constants and types for the cpu memory/I-O bridge.
// The I/O window sits at address bits 17:16 == 2'b11 of the 18-bit decoded space.
package mem_io_bridge_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int IO_AW  = 18;

  localparam logic [1:0]       IO_BASE_SEL  = 2'b11;
  localparam logic [IO_AW-1:0] IO_PORT_UART = 18'h30000;
  localparam logic [IO_AW-1:0] IO_PORT_CLK  = 18'h30004;

  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
    return w[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// Byte-wide cpu memory bus: the cpu drives address/data/write flag,
// the bridge returns read data and ready.
interface mem_io_bridge_if import mem_io_bridge_pkg::*;;

  logic [WORD_W-1:0] cpu_a;
  logic [BYTE_W-1:0] cpu_dout;
  logic              cpu_wr;
  logic [BYTE_W-1:0] cpu_din;
  logic              cpu_rdy;

  modport master (output cpu_a, cpu_dout, cpu_wr, input cpu_din, cpu_rdy);
  modport slave  (input cpu_a, cpu_dout, cpu_wr, output cpu_din, cpu_rdy);

endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; full/empty are purely registered so a
// pop in the same cycle never makes room for a push.
module byte_fifo import mem_io_bridge_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [BYTE_W-1:0] mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes cpu accesses to RAM or the I/O window, hosts the UART byte port,
// the free-running cycle counter with byte snapshot, and the sticky halt port.
module mem_io_bridge import mem_io_bridge_pkg::*; #(
  parameter int TX_DEPTH = 8,
  parameter int RAM_AW   = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sys_rdy_in,
  mem_io_bridge_if.slave    cpu,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [BYTE_W-1:0] ram_dout,
  input  logic [BYTE_W-1:0] ram_din,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              halt_out
);

  logic [IO_AW-1:0]  io_addr;
  logic              is_io;
  logic              rd_uart;
  logic              wr_uart;
  logic              wr_clk;
  logic              push_req;
  logic              stall;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] push_byte;
  logic [BYTE_W-1:0] io_rd_byte;
  logic [WORD_W-1:0] counter;
  logic [WORD_W-1:0] snapshot;
  logic [BYTE_W-1:0] io_byte;
  logic              halt_q;
  rd_src_e           rd_src;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu.cpu_a[WORD_W-1:IO_AW];

  assign io_addr  = cpu.cpu_a[IO_AW-1:0];
  assign is_io    = (io_addr[IO_AW-1:IO_AW-2] == IO_BASE_SEL);
  assign rd_uart  = !cpu.cpu_wr && (io_addr == IO_PORT_UART);
  assign wr_uart  = cpu.cpu_wr && (io_addr == IO_PORT_UART) && (cpu.cpu_dout != '0);
  assign wr_clk   = cpu.cpu_wr && (io_addr == IO_PORT_CLK);
  assign push_req = wr_uart || wr_clk;

  assign stall       = (push_req && fifo_full) || (rd_uart && !rx_valid);
  assign cpu.cpu_rdy = sys_rdy_in && !halt_q && !stall;
  // Reset gating keeps write strobes and pops quiet while rst_in is held low.
  assign accept      = cpu.cpu_rdy && rst_in;

  assign ram_a     = cpu.cpu_a[RAM_AW-1:0];
  assign ram_dout  = cpu.cpu_dout;
  assign ram_we    = accept && cpu.cpu_wr && !is_io;
  assign rx_pop    = accept && rd_uart;
  assign fifo_push = accept && push_req;
  assign push_byte = wr_clk ? '0 : cpu.cpu_dout;
  assign fifo_pop  = sys_rdy_in && tx_ready && !fifo_empty;
  assign tx_valid  = !fifo_empty;
  assign halt_out  = halt_q;

  assign cpu.cpu_din = !rst_in ? '0 : ((rd_src == SRC_IO) ? io_byte : ram_din);

  always_comb begin
    io_rd_byte = '0;
    if (io_addr == IO_PORT_UART)
      io_rd_byte = rx_data;
    else if (io_addr == IO_PORT_CLK)
      io_rd_byte = counter[BYTE_W-1:0];
    else if (io_addr[IO_AW-1:2] == IO_PORT_CLK[IO_AW-1:2])
      io_rd_byte = word_byte(snapshot, io_addr[1:0]);
  end

  // Reading the low counter byte freezes the whole count so the upper
  // bytes read afterwards belong to the same sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      counter  <= '0;
      snapshot <= '0;
      io_byte  <= '0;
      halt_q   <= 1'b0;
      rd_src   <= SRC_RAM;
    end else if (sys_rdy_in) begin
      counter <= counter + WORD_W'(1);
      if (accept && !cpu.cpu_wr) begin
        rd_src  <= is_io ? SRC_IO : SRC_RAM;
        io_byte <= io_rd_byte;
        if (io_addr == IO_PORT_CLK) snapshot <= counter;
      end
      if (fifo_push && wr_clk) halt_q <= 1'b1;
    end
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (fifo_push),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed and randomized bench for mem_io_bridge with a behavioural model
// of RAM contents, transmitted bytes and the cycle counter.
module tb_mem_io_bridge;
  import mem_io_bridge_pkg::*;

  localparam int TX_DEPTH = 8;
  localparam int RAM_AW   = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sys_rdy = 1'b0;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_pop;
  logic              halt_out;

  mem_io_bridge_if bus ();

  mem_io_bridge #(.TX_DEPTH(TX_DEPTH), .RAM_AW(RAM_AW)) dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .sys_rdy_in (sys_rdy),
    .cpu        (bus),
    .ram_a      (ram_a),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_pop     (rx_pop),
    .halt_out   (halt_out)
  );

  always #5 clk = ~clk;

  // External synchronous RAM: data appears the cycle after the address.
  logic [7:0] ram_mem [2**RAM_AW];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  // Reference cycle count: every clock with sys_rdy high since reset release.
  logic [31:0] model_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cnt <= '0;
    else if (sys_rdy) model_cnt <= model_cnt + 32'd1;
  end

  logic [7:0] tx_log [$];
  always @(negedge clk) begin
    if (rst_n && sys_rdy && tx_valid && tx_ready) tx_log.push_back(tx_data);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_ram [int];
  logic [7:0]  exp_tx [$];
  int          addrs [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cpu_a    = 32'h0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                                input bit rand_ready, output int stalls, output int pops);
    bit done;
    done = 0;
    stalls = 0;
    pops = 0;
    bus.cpu_a = a;
    bus.cpu_wr = wr;
    bus.cpu_dout = d;
    for (int i = 0; i < 300 && !done; i++) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      #1;
      if (rx_pop) pops++;
      if (bus.cpu_rdy) done = 1;
      else stalls++;
      tick();
    end
    check_output("access_done", 32'(done), 32'd1);
    bus_idle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no completion, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, pp, a, kind;
    logic [7:0] d;
    logic [31:0] snap;

    // Reset: drive a RAM write and a UART read to show they are suppressed.
    bus.cpu_a = 32'h5; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h33;
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h55; sys_rdy = 1'b1;
    #22;
    check_output("rst_ram_we", 32'(ram_we), 0);
    check_output("rst_tx_valid", 32'(tx_valid), 0);
    check_output("rst_halt", 32'(halt_out), 0);
    check_output("rst_cpu_din", 32'(bus.cpu_din), 0);
    bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b0;
    #1;
    check_output("rst_rx_pop", 32'(rx_pop), 0);
    bus_idle();
    rx_valid = 1'b0; tx_ready = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    $display("[TB] RAM directed and random");
    apply_stimulus(32'h10, 1'b1, 8'hA5, 0, st, pp);
    check_output("ram_wr_stall", 32'(st), 0);
    exp_ram[32'h10] = 8'hA5;
    addrs.push_back(32'h10);
    apply_stimulus(32'h10, 1'b0, 8'h00, 0, st, pp);
    check_output("ram_rd_a5", 32'(bus.cpu_din), 32'hA5);
    check_output("ram_rd_stall", 32'(st), 0);
    repeat (16) begin
      a = int'($urandom_range(0, 2**RAM_AW - 1));
      d = 8'($urandom);
      apply_stimulus(($urandom & 32'hFFFC_0000) | 32'(a), 1'b1, d, 0, st, pp);
      exp_ram[a] = d;
      addrs.push_back(a);
    end
    foreach (addrs[i]) begin
      apply_stimulus(32'(addrs[i]), 1'b0, 8'h00, 0, st, pp);
      check_output("ram_rd_rand", 32'(bus.cpu_din), 32'(exp_ram[addrs[i]]));
    end

    $display("[TB] UART transmit, zero drop");
    tx_ready = 1'b1;
    apply_stimulus(32'h30000, 1'b1, 8'h41, 0, st, pp);
    apply_stimulus(32'h30000, 1'b1, 8'h00, 0, st, pp);
    apply_stimulus(32'h30000, 1'b1, 8'h42, 0, st, pp);
    repeat (4) tick();
    check_output("tx_count", 32'(tx_log.size()), 2);
    check_output("tx_first", 32'(tx_log[0]), 32'h41);
    check_output("tx_second", 32'(tx_log[1]), 32'h42);
    tx_log.delete();

    $display("[TB] FIFO full stall");
    tx_ready = 1'b0;
    pp = 0;
    for (int i = 0; i < TX_DEPTH; i++) begin
      apply_stimulus(32'h30000, 1'b1, 8'(8'h10 + i), 0, st, kind);
      pp += st;
      exp_tx.push_back(8'(8'h10 + i));
    end
    check_output("fill_stalls", 32'(pp), 0);
    bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h99;
    repeat (3) begin
      #1 check_output("full_stall", 32'(bus.cpu_rdy), 0);
      tick();
    end
    tx_ready = 1'b1;
    #1 check_output("pop_no_passthru", 32'(bus.cpu_rdy), 0);
    tick();
    tx_ready = 1'b0;
    #1 check_output("ninth_admit", 32'(bus.cpu_rdy), 1);
    tick();
    bus_idle();
    exp_tx.push_back(8'h99);
    tx_ready = 1'b1;
    repeat (TX_DEPTH + 4) tick();
    tx_ready = 1'b0;
    check_output("drain_count", 32'(tx_log.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) check_output("drain_byte", 32'(tx_log[i]), 32'(exp_tx[i]));
    tx_log.delete();
    exp_tx.delete();

    $display("[TB] counter snapshot");
    repeat (2) begin
      repeat ($urandom_range(5, 20)) begin
        sys_rdy = 1'($urandom_range(0, 1));
        tick();
      end
      sys_rdy = 1'b1;
      snap = model_cnt;
      apply_stimulus(32'h30004, 1'b0, 8'h00, 0, st, pp);
      check_output("cnt_b0", 32'(bus.cpu_din), 32'(snap[7:0]));
      repeat ($urandom_range(1, 6)) begin
        sys_rdy = 1'($urandom_range(0, 1));
        tick();
      end
      sys_rdy = 1'b1;
      for (int b = 1; b < 4; b++) begin
        apply_stimulus(32'h30004 + 32'(b), 1'b0, 8'h00, 0, st, pp);
        check_output("cnt_snap_byte", 32'(bus.cpu_din), 32'(snap[b*8 +: 8]));
      end
    end
    apply_stimulus(32'h30002, 1'b0, 8'h00, 0, st, pp);
    check_output("io_other_rd", 32'(bus.cpu_din), 0);
    apply_stimulus(32'h3FFFF, 1'b0, 8'h00, 0, st, pp);
    check_output("io_top_rd", 32'(bus.cpu_din), 0);

    $display("[TB] UART receive");
    rx_valid = 1'b0;
    bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b0;
    repeat (3) begin
      #1 check_output("rx_wait_rdy", 32'(bus.cpu_rdy), 0);
      check_output("rx_wait_pop", 32'(rx_pop), 0);
      tick();
    end
    rx_valid = 1'b1; rx_data = 8'h7E;
    #1 check_output("rx_go_rdy", 32'(bus.cpu_rdy), 1);
    check_output("rx_go_pop", 32'(rx_pop), 1);
    tick();
    bus_idle();
    rx_valid = 1'b0;
    check_output("rx_data_7e", 32'(bus.cpu_din), 32'h7E);
    #1 check_output("rx_pop_single", 32'(rx_pop), 0);
    repeat (4) begin
      d = 8'($urandom);
      rx_valid = 1'b1; rx_data = d;
      apply_stimulus(32'h30000, 1'b0, 8'h00, 0, st, pp);
      check_output("rx_rand_pops", 32'(pp), 1);
      check_output("rx_rand_data", 32'(bus.cpu_din), 32'(d));
    end
    rx_valid = 1'b0;

    $display("[TB] random mixed traffic");
    repeat (40) begin
      kind = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      case (kind)
        0: begin
          apply_stimulus(32'h30000, 1'b1, d, 1, st, pp);
          if (d != 8'h00) exp_tx.push_back(d);
        end
        1: apply_stimulus(($urandom_range(0, 1) == 0) ? 32'h30008 : 32'(32'h30001 + $urandom_range(0, 2)),
                          1'b1, d, 1, st, pp);
        2: begin
          a = int'($urandom_range(0, 2**RAM_AW - 1));
          apply_stimulus(32'(a), 1'b1, d, 1, st, pp);
          exp_ram[a] = d;
          addrs.push_back(a);
        end
        default: begin
          a = addrs[$urandom_range(0, addrs.size() - 1)];
          apply_stimulus(32'(a), 1'b0, 8'h00, 1, st, pp);
          check_output("mix_ram_rd", 32'(bus.cpu_din), 32'(exp_ram[a]));
        end
      endcase
    end
    tx_ready = 1'b1;
    repeat (TX_DEPTH + 4) tick();
    tx_ready = 1'b0;
    check_output("mix_tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) check_output("mix_tx_byte", 32'(tx_log[i]), 32'(exp_tx[i]));
    tx_log.delete();

    $display("[TB] halt and async reset");
    apply_stimulus(32'h30000, 1'b1, 8'h61, 0, st, pp);
    apply_stimulus(32'h30000, 1'b1, 8'h62, 0, st, pp);
    apply_stimulus(32'h30004, 1'b1, 8'($urandom), 0, st, pp);
    check_output("halt_set", 32'(halt_out), 1);
    check_output("halt_rdy", 32'(bus.cpu_rdy), 0);
    check_output("halt_head", 32'(tx_data), 32'h61);
    bus.cpu_a = 32'h20; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h5A;
    repeat (3) begin
      #1 check_output("halt_hold_rdy", 32'(bus.cpu_rdy), 0);
      check_output("halt_hold_we", 32'(ram_we), 0);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    check_output("halt_drain", 32'(tx_log.size()), 2);
    check_output("halt_zero_queued", 32'(tx_data), 0);
    check_output("halt_valid", 32'(tx_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    check_output("areset_halt", 32'(halt_out), 0);
    check_output("areset_tx_valid", 32'(tx_valid), 0);
    check_output("areset_cpu_din", 32'(bus.cpu_din), 0);
    check_output("areset_rx_pop", 32'(rx_pop), 0);
    check_output("areset_ram_we", 32'(ram_we), 0);
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(32'h20, 1'b1, 8'h5A, 0, st, pp);
    check_output("post_rst_stall", 32'(st), 0);
    apply_stimulus(32'h20, 1'b0, 8'h00, 0, st, pp);
    check_output("post_rst_rd", 32'(bus.cpu_din), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the cpu top level, on the cpu's byte-wide memory bus (address, data in/out, write flag, ready).
- Decodes each access to either the 128KB synchronous RAM or the I/O window (mem_a[17:16]==2'b11).
- Implements the UART byte port, the 32-bit cycle counter and the program-stop port.
- Generates the cpu ready signal, stalling the cpu while an I/O access cannot complete.

Parameters:
- TX_DEPTH, 8, transmit FIFO entries; power of two, at least 2.
- RAM_AW, 17, RAM address width in bytes (128KB).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- sys_rdy_in  input  1  board-level ready; when low, the whole bridge holds state
- cpu_a  input  32  cpu address bus (mem_a); only bits 17:0 are decoded
- cpu_dout  input  8  cpu write data (mem_dout)
- cpu_wr  input  1  1 = write, 0 = read (mem_wr)
- cpu_din  output  8  read data to the cpu (mem_din)
- cpu_rdy  output  1  ready to the cpu (rdy_in)
- ram_a  output  RAM_AW  RAM address
- ram_we  output  1  RAM write enable
- ram_dout  output  8  RAM write data
- ram_din  input  8  RAM read data, valid the cycle after the address
- tx_data  output  8  UART transmit byte
- tx_valid  output  1  transmit FIFO non-empty
- tx_ready  input  1  UART accepts tx_data this cycle
- rx_data  input  8  UART received byte
- rx_valid  input  1  received byte available
- rx_pop  output  1  consume rx_data, one-cycle pulse
- halt_out  output  1  sticky program-stop flag

Behaviour:
- Reset (rst_in low, async): FIFO empty, counter 0, halt 0, snapshot 0, read-source register = RAM.
- Reset values: cpu_din=0, tx_valid=0, rx_pop=0, halt_out=0, ram_we=0.
- Accepted access: a cycle with sys_rdy_in=1 and cpu_rdy=1. With sys_rdy_in=0, nothing changes except the asynchronous reset path.
- Stall:
  - cpu_rdy = sys_rdy_in & ~halt_out & ~stall.
  - stall = (I/O write to 0x30000 with non-zero data while FIFO full) | (I/O read of 0x30000 while rx_valid=0).
  - Combinational; the cpu holds its bus while stalled.
- RAM path: ram_a=cpu_a[RAM_AW-1:0] combinational; ram_we = accepted & cpu_wr & ~io. RAM reads are never stalled.
- Read latency: one cycle after acceptance. The read-source select and the I/O read value are registered at acceptance; cpu_din muxes ram_din or the registered I/O byte in the next cycle.
- I/O reads:
  - 0x30000: returns rx_data; rx_pop pulses in the acceptance cycle.
  - 0x30004: returns counter[7:0] and latches the full counter into the snapshot.
  - 0x30005..0x30007: return snapshot bytes 1..3.
  - Other I/O addresses read 0.
- I/O writes:
  - 0x30000 with data 0x00: ignored.
  - 0x30000 with non-zero data: pushed to the FIFO.
  - 0x30004 (any data): pushes 0x00 and sets halt_out. This push happens even if the FIFO is full, stalling like a normal push until space is free.
  - Other I/O writes: ignored.
- Counter: 32 bits, +1 every clk_in with sys_rdy_in=1 from reset release; wraps modulo 2^32.
- FIFO:
  - Pop when tx_valid & tx_ready; push on an accepted write.
  - When full, a same-cycle pop does not admit a push (no pass-through); the stall lasts one more cycle.
  - When empty, a push becomes visible on tx_valid the following cycle.
  - Pointers are log2(TX_DEPTH)+1 bits and wrap naturally.
- Halt: after halt_out sets, cpu_rdy stays 0 until reset; the FIFO keeps draining to the UART.

Decomposition:
- Shared package: IO_BASE_SEL 2'b11, IO_PORT_UART 0x30000, IO_PORT_CLK 0x30004, byte and word widths.
- Sub-module byte_fifo (parameter DEPTH): push/pop/full/empty/data, with the same clock and reset.

Test Plan:
- RAM write 0x00010=0xA5, then read 0x00010 -> cpu_din=0xA5 exactly one cycle after the read is accepted; cpu_rdy stays 1.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence is 0x41 then 0x42; the 0x00 write is dropped.
- tx_ready=0, nine non-zero writes with TX_DEPTH=8 -> cpu_rdy=0 on the ninth; raise tx_ready for one cycle -> the ninth write is accepted one cycle later.
- Counter at 0x12345678 when 0x30004 is read, then 0x30005..0x30007 read -> bytes 0x78, 0x56, 0x34, 0x12 (snapshot consistent).
- Read 0x30000 with rx_valid=0 for 3 cycles, then rx_valid=1 with rx_data=0x7E -> cpu_rdy low 3 cycles, a single rx_pop, cpu_din=0x7E.
- Write 0x30004, then assert rst_in low mid-transmit -> 0x00 enqueued, halt_out=1, cpu_rdy=0; on reset all outputs return to reset values asynchronously.
